// File: rtl/pixel_capture_80x40.sv
// pixel_capture_80x40
//
// Captures an 80x40 window out of a pixel stream from a drawing engine and
// re-emits each in-window pixel as a write into a window-sized RAM. It
// stops on its own once every window location has been written.
//
// Ports
//   clk           rising-edge clock
//   resetn        asynchronous active-low reset
//   enable        level; high holds a capture session open, low aborts it
//   plot          pixel valid from the drawing side
//   x, y          screen coordinates of the offered pixel
//   colour        pixel colour
//   ready         pixel taken on an edge where plot and ready are both high
//   mem_address   window RAM write address, row-major, 0..W*H-1
//   mem_data      window RAM write data
//   mem_wren      one-cycle write strobe
//   capture_done  W*H writes issued; holds until enable drops
//   drop_count    accepted pixels that fell outside the window (saturates)
module pixel_capture_80x40 #(
  parameter int X0 = 39,
  parameter int Y0 = 39,
  parameter int W  = 80,
  parameter int H  = 40
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        plot,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [8:0]  colour,
  output logic        ready,
  output logic [11:0] mem_address,
  output logic [8:0]  mem_data,
  output logic        mem_wren,
  output logic        capture_done,
  output logic [7:0]  drop_count
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam int          DEPTH      = 4;
  localparam logic [11:0] LAST_WRITE = 12'(W * H - 1);
  // Bounds are one bit wider than the coordinates so X0+W / Y0+H cannot wrap.
  localparam logic [8:0]  X_LO       = 9'(X0);
  localparam logic [8:0]  X_HI       = 9'(X0 + W);
  localparam logic [7:0]  Y_LO       = 8'(Y0);
  localparam logic [7:0]  Y_HI       = 8'(Y0 + H);
  localparam logic [7:0]  X_OFF      = 8'(X0);
  localparam logic [6:0]  Y_OFF      = 7'(Y0);

  state_t      state_reg, state_next;

  // FIFO entries are {address, colour}.
  logic [20:0] entry_reg [DEPTH];
  logic [DEPTH-1:0] entry_we;
  logic [1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [2:0]  count_reg;
  logic [11:0] wr_count_reg;
  logic [7:0]  drop_count_reg;

  logic        in_window;
  logic        accept;
  logic        push;
  logic        pop;
  logic [7:0]  dx;
  logic [6:0]  dy;
  logic [11:0] pix_addr;
  logic [20:0] head;

  // ------------------------------------------------------------------
  // Pixel classification and address generation
  // ------------------------------------------------------------------
  assign in_window = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                     ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);

  assign dx = x - X_OFF;
  assign dy = y - Y_OFF;
  // Row stride of 80 built as 64 + 16 so no multiplier is inferred.
  assign pix_addr = ({5'd0, dy} << 6) + ({5'd0, dy} << 4) + {4'd0, dx};

  assign accept = plot && ready;
  // Gated by enable so nothing is queued or written on the aborting edge.
  assign push   = accept && in_window && enable;
  assign pop    = (state_reg == CAPTURE) && enable && (count_reg != 3'd0);
  assign head   = entry_reg[rd_ptr_reg];

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ready        = 1'b0;
    capture_done = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE:    state_next = CAPTURE;
        // Finish on the edge that issues the last write.
        CAPTURE: if (pop && (wr_count_reg == LAST_WRITE)) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
    ready        = (state_reg == CAPTURE) && (count_reg != 3'(DEPTH));
    capture_done = (state_reg == DONE);
  end

  // ------------------------------------------------------------------
  // FIFO storage: one write enable per slot
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
    assign entry_we[gi] = push && (wr_ptr_reg == 2'(gi));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_we[i]) entry_reg[i] <= {pix_addr, colour};
      end
    end
  end

  // ------------------------------------------------------------------
  // FIFO control, write stage and counters
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      wr_count_reg   <= '0;
      drop_count_reg <= '0;
      mem_wren       <= 1'b0;
      mem_address    <= '0;
      mem_data       <= '0;
    end else if (!enable) begin
      // Session abort / idle: everything back to empty, no strobe.
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      wr_count_reg   <= '0;
      drop_count_reg <= '0;
      mem_wren       <= 1'b0;
    end else begin
      mem_wren <= pop;
      if (pop) begin
        mem_address  <= head[20:9];
        mem_data     <= head[8:0];
        wr_count_reg <= wr_count_reg + 12'd1;
      end

      if (accept && !in_window && (drop_count_reg != 8'hFF)) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end

      if (state_next != CAPTURE) begin
        // Entering DONE throws away anything still queued.
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
        count_reg <= count_reg + {2'd0, push} - {2'd0, pop};
      end
    end
  end

  assign drop_count = drop_count_reg;

endmodule
